radar_pulse_sequencer: RTL and testbench
========================================

// Module: radar_pulse_sequencer
// PURPOSE
// - Sequences the FMC150 chirp DAC and ADC capture path for repeated radar pulses:
//   chirp_init -> wait chirp_ready -> chirp_enable -> delayed adc_enable window -> chirp_done -> PRF guard.
// - Sits in the clk_245_76MHz domain between the control registers and the fmc150 DAC/ADC block.
// - Its adc_enable drives the ADC FIFO write gate, which has a 2-flop delay; that delay moves both window edges equally.
// PARAMETERS
// - CNT_WIDTH       32    width of capture-length, PRF-period and sample counters
// - PULSE_WIDTH     16    width of pulse-count config and counter
// - DLY_WIDTH       16    width of the ADC start-delay config
// - TIMEOUT_CYCLES  4096  max cycles spent in ARM or WAIT_DONE before a timeout error
// PORTS
// - clk_245_76MHz     in   1            sequencer clock
// - cpu_reset         in   1            reset: synchronous, active-high
// - seq_start         in   1            1-cycle start pulse; ignored unless state==IDLE
// - seq_abort         in   1            level; forces IDLE (has priority over all other events)
// - cfg_continuous    in   1            1 = repeat pulses until abort; cfg_num_pulses is ignored
// - cfg_num_pulses    in   PULSE_WIDTH  pulses per sequence
// - cfg_adc_delay     in   DLY_WIDTH    cycles from chirp_enable rise to adc_enable rise
// - cfg_capture_len   in   CNT_WIDTH    ADC samples per pulse (counted on adc_data_valid)
// - cfg_prf_period    in   CNT_WIDTH    cycles from one INIT entry to the next
// - chirp_ready       in   1            DDS ready after init
// - chirp_done        in   1            1-cycle pulse at chirp end
// - adc_data_valid    in   1            ADC sample strobe
// - adc_fifo_almost_full in 1           ADC FIFO write-side almost_full
// - chirp_init        out  1            1-cycle pulse on INIT entry
// - chirp_enable      out  1            level, registered
// - adc_enable        out  1            level, registered
// - seq_busy          out  1            state != IDLE
// - seq_done          out  1            1-cycle pulse on normal completion
// - seq_error         out  2            sticky; [0]=timeout, [1]=overflow; cleared by accepted seq_start
// - pulse_count       out  PULSE_WIDTH  pulses completed in the current sequence
// - sample_count      out  CNT_WIDTH    samples captured in the current pulse
// - seq_state         out  3            encoded state, for ILA/status use
// BEHAVIOUR
// - Reset: all outputs 0; state = IDLE; internal counters and flags 0.
// - All cfg_* values are latched on an accepted seq_start and held for the whole sequence.
// - States and encodings:
//   - IDLE(0): on seq_start, if !cfg_continuous && cfg_num_pulses==0, pulse seq_done next cycle and stay IDLE.
//     Otherwise go to INIT.
//   - INIT(1): chirp_init=1 for exactly one cycle; period counter cleared; go to ARM.
//   - ARM(2): wait for chirp_ready, then go to FIRE with chirp_enable=1.
//   - FIRE(3): count delay cycles; at count==cfg_adc_delay go to CAPTURE with adc_enable=1
//     (delay 0 means chirp_enable and adc_enable rise on the same cycle).
//     If cfg_capture_len==0, skip straight to WAIT_DONE and never assert adc_enable.
//   - CAPTURE(4): sample_count increments on each adc_data_valid while adc_enable=1.
//     On the valid that makes sample_count==cfg_capture_len, drop adc_enable next cycle and go to WAIT_DONE.
//   - WAIT_DONE(5): wait for chirp_done, or use the latched done_seen flag, then drop chirp_enable
//     and increment pulse_count.
//     Go to IDLE with a seq_done pulse if the pulse count is reached and !cfg_continuous; otherwise go to GUARD.
//   - GUARD(6): wait until the period counter >= cfg_prf_period-1, then go to INIT.
//     If the period has already elapsed, go to INIT on the next cycle.
// - chirp_done arriving in FIRE or CAPTURE sets done_seen; chirp_enable stays high until WAIT_DONE.
// - Timeout: ARM or WAIT_DONE exceeding TIMEOUT_CYCLES sets seq_error[0], clears both enables, goes to IDLE.
//   No seq_done pulse.
// - Abort: from any state -> IDLE next cycle with both enables 0; no seq_done pulse; counters hold for readback.
// - seq_start and seq_abort in the same cycle: abort wins.
// - pulse_count and sample_count wrap modulo 2^width; in continuous mode pulse_count wraps silently.
// CONFIGURATION
// - SEQ_OVERFLOW_STOP_EN defined:
//   - adc_fifo_almost_full seen in CAPTURE sets seq_error[1].
//   - adc_enable drops next cycle and the state goes to WAIT_DONE; the pulse still counts as completed.
// - SEQ_OVERFLOW_STOP_EN undefined: adc_fifo_almost_full is ignored and seq_error[1] is tied to 0.
// TESTING
// 1. num_pulses=2, delay=4, len=8, period=100, ready 3 cycles after init, valid every cycle
//    -> two chirp_init pulses 100 cycles apart; adc_enable high 8 cycles, rising 4 cycles after chirp_enable.
//    -> seq_done once; pulse_count=2.
// 2. Hold chirp_ready low -> after 4096 cycles in ARM: seq_error=2'b01, chirp_enable=0, seq_busy=0, no seq_done.
// 3. cfg_continuous=1, then seq_abort mid-CAPTURE -> adc_enable and chirp_enable are 0 on the next cycle.
//    -> state IDLE; sample_count holds its partial value.
// 4. cfg_capture_len=0, then cfg_num_pulses=0 -> first: no adc_enable pulse, pulse completes on chirp_done.
//    -> second: seq_done one cycle after seq_start, no chirp_init.
// 5. chirp_done arrives in CAPTURE before len=16 samples -> capture finishes all 16 samples.
//    -> WAIT_DONE exits on the next cycle via done_seen.
// 6. With SEQ_OVERFLOW_STOP_EN: almost_full raised at sample 5 of 16 -> adc_enable drops next cycle.
//    -> seq_error=2'b10; sequence continues to the next pulse.

Source files
------------

// File: rtl/radar_pulse_sequencer_if.sv
// FMC150 chirp/ADC side of the radar pulse sequencer.
// master = sequencer (drives chirp_init/chirp_enable/adc_enable), slave = fmc150 block.
interface radar_pulse_sequencer_if;
  logic chirp_ready;
  logic chirp_done;
  logic adc_data_valid;
  logic adc_fifo_almost_full;
  logic chirp_init;
  logic chirp_enable;
  logic adc_enable;

  modport master (
    input  chirp_ready,
    input  chirp_done,
    input  adc_data_valid,
    input  adc_fifo_almost_full,
    output chirp_init,
    output chirp_enable,
    output adc_enable
  );

  modport slave (
    output chirp_ready,
    output chirp_done,
    output adc_data_valid,
    output adc_fifo_almost_full,
    input  chirp_init,
    input  chirp_enable,
    input  adc_enable
  );
endinterface

// File: rtl/radar_pulse_sequencer.sv
// Radar pulse sequencer: chirp_init -> ready -> chirp_enable -> delayed ADC window -> done -> PRF guard.
// Ports: clk_245_76MHz, cpu_reset (sync, active-high), seq_* control/status, cfg_* config,
//        fmc (radar_pulse_sequencer_if.master) to the DAC/ADC block.
// Option: SEQ_OVERFLOW_STOP_EN ends capture early on adc_fifo_almost_full and flags seq_error[1].
module radar_pulse_sequencer #(
  parameter int CNT_WIDTH      = 32,
  parameter int PULSE_WIDTH    = 16,
  parameter int DLY_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk_245_76MHz,
  input  logic                   cpu_reset,
  input  logic                   seq_start,
  input  logic                   seq_abort,
  input  logic                   cfg_continuous,
  input  logic [PULSE_WIDTH-1:0] cfg_num_pulses,
  input  logic [DLY_WIDTH-1:0]   cfg_adc_delay,
  input  logic [CNT_WIDTH-1:0]   cfg_capture_len,
  input  logic [CNT_WIDTH-1:0]   cfg_prf_period,
  radar_pulse_sequencer_if.master fmc,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [1:0]             seq_error,
  output logic [PULSE_WIDTH-1:0] pulse_count,
  output logic [CNT_WIDTH-1:0]   sample_count,
  output logic [2:0]             seq_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_FIRE    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_GUARD   = 3'd6;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state_q, state_d;
  logic                   cont_q, cont_d;
  logic [PULSE_WIDTH-1:0] num_q, num_d;
  logic [DLY_WIDTH-1:0]   dly_cfg_q, dly_cfg_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   prf_cfg_q, prf_cfg_d;
  logic [DLY_WIDTH-1:0]   dly_cnt_q, dly_cnt_d;
  logic [CNT_WIDTH-1:0]   prf_cnt_q, prf_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [PULSE_WIDTH-1:0] pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]   sample_q, sample_d;
  logic                   done_seen_q, done_seen_d;
  logic                   init_q, init_d;
  logic                   chirp_en_q, chirp_en_d;
  logic                   adc_en_q, adc_en_d;
  logic                   seq_done_q, seq_done_d;
  logic [1:0]             err_q, err_d;

  logic [PULSE_WIDTH-1:0] pulse_inc;
  logic [CNT_WIDTH-1:0]   sample_inc;
  logic                   last_pulse;
  logic                   prf_elapsed;
  logic [2:0]             fire_exit;

  assign pulse_inc  = pulse_q + PULSE_WIDTH'(1);
  assign sample_inc = sample_q + CNT_WIDTH'(1);
  assign last_pulse = !cont_q && (pulse_inc == num_q);
  // widened so a zero period means "already elapsed"
  assign prf_elapsed = ({1'b0, prf_cnt_q} + (CNT_WIDTH+1)'(1))
                       >= {1'b0, prf_cfg_q};
  // a zero capture length skips the ADC window entirely
  assign fire_exit = (len_q == '0) ? S_WAIT : S_CAPTURE;

`ifdef SEQ_OVERFLOW_STOP_EN
  logic af_stop;
  assign af_stop = fmc.adc_fifo_almost_full;
`else
  logic af_stop;
  logic unused_af;
  assign af_stop   = 1'b0;
  assign unused_af = fmc.adc_fifo_almost_full;
`endif

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    num_d       = num_q;
    dly_cfg_d   = dly_cfg_q;
    len_d       = len_q;
    prf_cfg_d   = prf_cfg_q;
    dly_cnt_d   = dly_cnt_q;
    prf_cnt_d   = prf_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    pulse_d     = pulse_q;
    sample_d    = sample_q;
    done_seen_d = done_seen_q;
    seq_done_d  = 1'b0;
    err_d       = err_q;

    if (seq_abort) begin
      // counters and flags hold for readback
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (seq_start) begin
            cont_d    = cfg_continuous;
            num_d     = cfg_num_pulses;
            dly_cfg_d = cfg_adc_delay;
            len_d     = cfg_capture_len;
            prf_cfg_d = cfg_prf_period;
            err_d     = 2'b00;
            pulse_d   = '0;
            sample_d  = '0;
            if (!cfg_continuous && cfg_num_pulses == '0)
              seq_done_d = 1'b1;
            else
              state_d = S_INIT;
          end
        end
        S_INIT: begin
          sample_d    = '0;
          done_seen_d = 1'b0;
          state_d     = S_ARM;
        end
        S_ARM: begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (fmc.chirp_ready) begin
            dly_cnt_d = '0;
            state_d   = (dly_cfg_q == '0) ? fire_exit : S_FIRE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_d[0] = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_FIRE: begin
          dly_cnt_d = dly_cnt_q + DLY_WIDTH'(1);
          if (fmc.chirp_done) done_seen_d = 1'b1;
          if (dly_cnt_d == dly_cfg_q) state_d = fire_exit;
        end
        S_CAPTURE: begin
          if (fmc.chirp_done) done_seen_d = 1'b1;
          if (fmc.adc_data_valid) begin
            sample_d = sample_inc;
            if (sample_inc == len_q) state_d = S_WAIT;
          end
          if (af_stop) begin
            err_d[1] = 1'b1;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (fmc.chirp_done || done_seen_q) begin
            pulse_d     = pulse_inc;
            done_seen_d = 1'b0;
            if (last_pulse) begin
              seq_done_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              state_d = S_GUARD;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_d[0] = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_GUARD: begin
          if (prf_elapsed) state_d = S_INIT;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // period counter reads 0 in the INIT cycle
    if (state_d == S_INIT)
      prf_cnt_d = '0;
    else if (state_q != S_IDLE)
      prf_cnt_d = prf_cnt_q + CNT_WIDTH'(1);

    // timeout counts residency in the current state
    if (state_d != state_q) tmo_cnt_d = '0;

    init_d     = (state_d == S_INIT);
    chirp_en_d = (state_d == S_FIRE) || (state_d == S_CAPTURE) ||
                 (state_d == S_WAIT);
    adc_en_d   = (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk_245_76MHz) begin
    if (cpu_reset) begin
      state_q     <= S_IDLE;
      cont_q      <= 1'b0;
      num_q       <= '0;
      dly_cfg_q   <= '0;
      len_q       <= '0;
      prf_cfg_q   <= '0;
      dly_cnt_q   <= '0;
      prf_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      pulse_q     <= '0;
      sample_q    <= '0;
      done_seen_q <= 1'b0;
      init_q      <= 1'b0;
      chirp_en_q  <= 1'b0;
      adc_en_q    <= 1'b0;
      seq_done_q  <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      num_q       <= num_d;
      dly_cfg_q   <= dly_cfg_d;
      len_q       <= len_d;
      prf_cfg_q   <= prf_cfg_d;
      dly_cnt_q   <= dly_cnt_d;
      prf_cnt_q   <= prf_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pulse_q     <= pulse_d;
      sample_q    <= sample_d;
      done_seen_q <= done_seen_d;
      init_q      <= init_d;
      chirp_en_q  <= chirp_en_d;
      adc_en_q    <= adc_en_d;
      seq_done_q  <= seq_done_d;
      err_q       <= err_d;
    end
  end

  assign fmc.chirp_init   = init_q;
  assign fmc.chirp_enable = chirp_en_q;
  assign fmc.adc_enable   = adc_en_q;
  assign seq_busy         = (state_q != S_IDLE);
  assign seq_done         = seq_done_q;
  assign seq_error        = err_q;
  assign pulse_count      = pulse_q;
  assign sample_count     = sample_q;
  assign seq_state        = state_q;

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// Directed bench for radar_pulse_sequencer with a small DDS/ADC responder.
// Build with +define+SEQ_OVERFLOW_STOP_EN to exercise the overflow stop.
module tb_radar_pulse_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        seq_start, seq_abort, cfg_continuous;
  logic [15:0] cfg_num_pulses, cfg_adc_delay;
  logic [31:0] cfg_capture_len, cfg_prf_period;
  logic        seq_busy, seq_done;
  logic [1:0]  seq_error;
  logic [15:0] pulse_count;
  logic [31:0] sample_count;
  logic [2:0]  seq_state;

  radar_pulse_sequencer_if fmc ();

  radar_pulse_sequencer #(
    .CNT_WIDTH(32), .PULSE_WIDTH(16), .DLY_WIDTH(16), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk_245_76MHz (clk),
    .cpu_reset     (rst),
    .seq_start     (seq_start),
    .seq_abort     (seq_abort),
    .cfg_continuous(cfg_continuous),
    .cfg_num_pulses(cfg_num_pulses),
    .cfg_adc_delay (cfg_adc_delay),
    .cfg_capture_len(cfg_capture_len),
    .cfg_prf_period(cfg_prf_period),
    .fmc           (fmc.master),
    .seq_busy      (seq_busy),
    .seq_done      (seq_done),
    .seq_error     (seq_error),
    .pulse_count   (pulse_count),
    .sample_count  (sample_count),
    .seq_state     (seq_state)
  );

  int n_chk = 0;
  int n_pass = 0;

  int cyc = 0;
  int init_t[$];
  int init_n, init_cyc, ce_rise, adc_rise, adc_hi, done_n, arm_n, wd_n;
  bit init_seen, ce_seen, ce_prev, adc_prev;
  int ready_after = 3;
  int done_after = 20;
  bit ready_en, valid_en, af_en;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr();
    init_t.delete();
    init_n = 0; init_cyc = 0; ce_rise = 0; adc_rise = 0;
    adc_hi = 0; done_n = 0; arm_n = 0; wd_n = 0;
    init_seen = 0; ce_seen = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (fmc.chirp_init) begin
      init_t.push_back(cyc);
      init_n++;
      init_seen = 1;
      init_cyc = cyc;
    end
    if (fmc.chirp_enable && !ce_prev) begin
      ce_rise = cyc;
      ce_seen = 1;
    end
    if (fmc.adc_enable && !adc_prev) adc_rise = cyc;
    if (fmc.adc_enable) adc_hi++;
    if (seq_done) done_n++;
    if (seq_state == 3'd2) arm_n++;
    if (seq_state == 3'd5) wd_n++;
    ce_prev  = fmc.chirp_enable;
    adc_prev = fmc.adc_enable;
    fmc.chirp_ready = ready_en && init_seen && (cyc - init_cyc >= ready_after);
    fmc.chirp_done  = (done_after >= 0) && ce_seen && (cyc == ce_rise + done_after);
    fmc.adc_data_valid = valid_en;
    fmc.adc_fifo_almost_full = af_en && (seq_state == 3'd4) &&
                               (sample_count >= 32'd5) && (pulse_count == 16'd0);
  endtask

  task automatic start();
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic run_idle(input int max, input string tag);
    int n = 0;
    tick();
    while (seq_busy && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 64'(seq_busy), 64'd0);
  endtask

  task automatic cfg(input bit c, input int np, input int dl,
                     input int ln, input int pr);
    cfg_continuous  = c;
    cfg_num_pulses  = 16'(np);
    cfg_adc_delay   = 16'(dl);
    cfg_capture_len = 32'(ln);
    cfg_prf_period  = 32'(pr);
  endtask

  initial begin
    rst = 1'b1;
    seq_start = 0; seq_abort = 0;
    cfg(0, 0, 0, 0, 0);
    fmc.chirp_ready = 0; fmc.chirp_done = 0;
    fmc.adc_data_valid = 0; fmc.adc_fifo_almost_full = 0;
    ready_en = 1; valid_en = 1; af_en = 0;
    clr();
    repeat (3) tick();
    chk("rst_state", 64'(seq_state), 64'd0);
    chk("rst_busy", 64'(seq_busy), 64'd0);
    chk("rst_outs", 64'({fmc.chirp_init, fmc.chirp_enable, fmc.adc_enable, seq_done}), 64'd0);
    chk("rst_err", 64'(seq_error), 64'd0);
    chk("rst_cnts", 64'(pulse_count) + 64'(sample_count), 64'd0);
    rst = 1'b0;
    tick();

    // two pulses, delay 4, len 8, period 100
    clr();
    cfg(0, 2, 4, 8, 100);
    start();
    run_idle(1000, "t1");
    chk("t1_inits", 64'(init_n), 64'd2);
    chk("t1_prf", 64'(init_t[1] - init_t[0]), 64'd100);
    chk("t1_adc_dly", 64'(adc_rise - ce_rise), 64'd4);
    chk("t1_adc_hi", 64'(adc_hi), 64'd16);
    chk("t1_done", 64'(done_n), 64'd1);
    chk("t1_pulses", 64'(pulse_count), 64'd2);
    chk("t1_err", 64'(seq_error), 64'd0);

    // chirp_ready never comes: ARM timeout
    clr();
    ready_en = 0;
    cfg(0, 1, 4, 8, 100);
    start();
    run_idle(5000, "t2");
    chk("t2_arm_cycles", 64'(arm_n), 64'd4096);
    chk("t2_err", 64'(seq_error), 64'd1);
    chk("t2_chirp_en", 64'(fmc.chirp_enable), 64'd0);
    chk("t2_done", 64'(done_n), 64'd0);
    ready_en = 1;

    // continuous, abort mid-capture
    clr();
    cfg(1, 0, 2, 16, 100);
    start();
    begin
      int n = 0;
      while (!(seq_state == 3'd4 && sample_count == 32'd5) && n < 200) begin
        tick();
        n++;
      end
    end
    chk("t3_reach_capture", 64'(seq_state), 64'd4);
    chk("t3_err_cleared", 64'(seq_error), 64'd0);
    seq_abort = 1'b1;
    tick();
    chk("t3_enables", 64'({fmc.chirp_enable, fmc.adc_enable}), 64'd0);
    chk("t3_state", 64'(seq_state), 64'd0);
    chk("t3_samples", 64'(sample_count), 64'd5);
    seq_abort = 1'b0;
    tick();
    chk("t3_hold", 64'(sample_count), 64'd5);
    chk("t3_done", 64'(done_n), 64'd0);
    seq_abort = 1'b1;
    seq_start = 1'b1;
    tick();
    seq_abort = 1'b0;
    seq_start = 1'b0;
    chk("t3_abort_wins", 64'(seq_busy), 64'd0);
    tick();
    chk("t3_abort_wins2", 64'(seq_busy), 64'd0);

    // zero capture length completes on chirp_done
    clr();
    done_after = 10;
    cfg(0, 1, 3, 0, 100);
    start();
    run_idle(500, "t4a");
    chk("t4a_adc_hi", 64'(adc_hi), 64'd0);
    chk("t4a_wait", 64'(wd_n), 64'd8);
    chk("t4a_pulses", 64'(pulse_count), 64'd1);
    chk("t4a_done", 64'(done_n), 64'd1);

    // zero pulses: immediate seq_done
    clr();
    cfg(0, 0, 3, 8, 100);
    start();
    chk("t4b_done", 64'(seq_done), 64'd1);
    chk("t4b_busy", 64'(seq_busy), 64'd0);
    tick();
    chk("t4b_done_pulse", 64'(seq_done), 64'd0);
    chk("t4b_no_init", 64'(init_n), 64'd0);

    // chirp_done early in capture
    clr();
    done_after = 5;
    cfg(0, 1, 1, 16, 100);
    start();
    run_idle(500, "t5");
    chk("t5_samples", 64'(sample_count), 64'd16);
    chk("t5_wait", 64'(wd_n), 64'd1);
    chk("t5_pulses", 64'(pulse_count), 64'd1);
    chk("t5_done", 64'(done_n), 64'd1);

    // almost_full at sample 5 of pulse 1
    clr();
    done_after = 20;
    af_en = 1;
    cfg(0, 2, 2, 16, 100);
    start();
    run_idle(1000, "t6");
    af_en = 0;
    chk("t6_pulses", 64'(pulse_count), 64'd2);
    chk("t6_done", 64'(done_n), 64'd1);
`ifdef SEQ_OVERFLOW_STOP_EN
    chk("t6_err", 64'(seq_error), 64'd2);
    chk("t6_adc_hi", 64'(adc_hi), 64'd22);
`else
    chk("t6_err", 64'(seq_error), 64'd0);
    chk("t6_adc_hi", 64'(adc_hi), 64'd32);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
